rx_aurora_readout_arbiter: RTL and testbench
============================================

Name: rx_aurora_readout_arbiter

Overview:
- Round-robin readout arbiter that merges the 32-bit readout FIFOs of CHANNELS rx_aurora_64b66b instances into a single FIFO-style port.
- Sits between the Aurora receivers and the downstream readout (e.g. the SiTCP/USB FIFO path).
- Grants one channel at a time, in bursts of at most MAX_BURST words, so that no lane can starve the others.
- All channel FIFOs are first-word-fall-through: data is valid whenever EMPTY is low, and READ acknowledges that word.

Parameters:
- CHANNELS, 4, number of Aurora receivers; legal range 2..16.
- MAX_BURST, 16, maximum words read from one channel per grant; legal range 1..256.

Ports:
- BUS_CLK  input  1  single clock for all logic and all FIFO ports.
- BUS_RST_N  input  1  asynchronous, active-low reset.
- CH_ENABLE  input  CHANNELS  per-channel arbitration enable (static configuration).
- CH_FIFO_EMPTY  input  CHANNELS  EMPTY flag of each channel FIFO.
- CH_FIFO_DATA  input  32*CHANNELS  FIFO data; channel i occupies bits [32*i+31:32*i].
- CH_FIFO_READ  output  CHANNELS  read strobe to each channel FIFO.
- FIFO_READ  input  1  downstream read strobe.
- FIFO_EMPTY  output  1  merged EMPTY flag.
- FIFO_DATA  output  32  merged data.
- GRANT_VALID  output  1  a channel currently holds the grant.
- GRANT_ID  output  4  index of the granted channel.

Behaviour:
- One clock, BUS_CLK; reset is asynchronous and active-low (BUS_RST_N).
- Reset values:
  - state = IDLE; last = CHANNELS-1, so the first search starts at channel 0.
  - burst_cnt = 0; GRANT_VALID = 0; GRANT_ID = 0.
  - FIFO_EMPTY = 1; FIFO_DATA = 0; CH_FIFO_READ = 0.
- State IDLE:
  - FIFO_EMPTY = 1, FIFO_DATA = 0, CH_FIFO_READ = 0.
  - Combinational search in order last+1, last+2, ... (mod CHANNELS) for the first channel with CH_ENABLE=1 and CH_FIFO_EMPTY=0.
  - If one is found: register grant g and burst_cnt = 0, then go to GRANT on the next edge.
  - Arbitration latency is exactly 1 cycle.
- State GRANT, outputs (pure combinational pass-through of channel g, no data latency):
  - FIFO_EMPTY = CH_FIFO_EMPTY[g] | ~CH_ENABLE[g].
  - FIFO_DATA = CH_FIFO_DATA[g].
  - CH_FIFO_READ[g] = FIFO_READ & ~FIFO_EMPTY; every other CH_FIFO_READ bit is 0.
  - GRANT_VALID = 1, GRANT_ID = g.
- State GRANT, per-cycle update:
  - On an accepted read (FIFO_READ & ~FIFO_EMPTY), burst_cnt increments.
  - Release to IDLE (last = g) on the same edge when either:
    - an accepted read makes burst_cnt reach MAX_BURST; or
    - no read is accepted and FIFO_EMPTY = 1 (channel drained or disabled).
- Gap between grants: IDLE always lasts at least 1 cycle, and FIFO_EMPTY = 1 during it.
- FIFO_READ while FIFO_EMPTY = 1 is ignored: no channel read and no counter change.
- An accepted read on the last word, which makes the channel empty on the following cycle, does not release the grant until that following cycle.
- CH_ENABLE deasserting mid-burst:
  - FIFO_EMPTY rises in the same cycle (combinational).
  - Release to IDLE happens on the next edge.
  - No word is lost.
- Only one channel requesting: after its burst it is re-granted following one IDLE cycle.
- No channel requesting: the block stays in IDLE; `last` is unchanged.
- Reset mid-burst: returns immediately to the reset values; any word not yet read stays in its channel FIFO.
- GRANT_ID width is fixed at 4 bits; unused upper bits are 0.

Optional Feature:
- Macro: ARB_CHANNEL_TAG_EN.
- Defined: in GRANT, FIFO_DATA[31:28] = g and FIFO_DATA[27:0] = CH_FIFO_DATA[32*g+27:32*g]; the channel's upper nibble is discarded. Data stays 0 in IDLE.
- Undefined: FIFO_DATA carries the channel's 32 bits unmodified.

Test Plan:
- Reset, then all channels empty and enabled -> FIFO_EMPTY=1, GRANT_VALID=0 for 100 cycles; CH_FIFO_READ never asserts.
- Ch1 holds 5 words (0xA0..0xA4), FIFO_READ held high -> GRANT_ID=1 one cycle after its EMPTY falls. Output is 0xA0..0xA4 on consecutive cycles, then release to IDLE. CH_FIFO_READ[1] pulses exactly 5 times.
- MAX_BURST=4; ch0 and ch2 each hold 10 words; continuous read -> grant order 0,2,0,2,0,2 with 4,4,4,4,2,2 words. Each burst is separated by 1 cycle of FIFO_EMPTY=1.
- Ch3 granted, downstream pulls 2 words, then CH_ENABLE[3]=0 -> FIFO_EMPTY=1 in the same cycle, IDLE on the next edge, 2 words consumed. Ch3 is not re-granted while disabled.
- BUS_RST_N asserted while ch0 is mid-burst (burst_cnt=3) -> all outputs at reset values asynchronously. After release, arbitration restarts at ch0 with burst_cnt=0.
- ARB_CHANNEL_TAG_EN defined, ch2 word 0xFFFF_1234 -> FIFO_DATA=0x2FFF_1234. Undefined -> FIFO_DATA=0xFFFF_1234.

Source files
------------

// File: rtl/rx_aurora_readout_arbiter.sv
// Round-robin burst arbiter merging CHANNELS first-word-fall-through readout FIFOs into one port.
// Optional build macro ARB_CHANNEL_TAG_EN replaces FIFO_DATA[31:28] with the granted channel index.
module rx_aurora_readout_arbiter #(
    parameter int CHANNELS  = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST_N,
    input  logic [CHANNELS-1:0]      CH_ENABLE,
    input  logic [CHANNELS-1:0]      CH_FIFO_EMPTY,
    input  logic [32*CHANNELS-1:0]   CH_FIFO_DATA,
    output logic [CHANNELS-1:0]      CH_FIFO_READ,
    input  logic                     FIFO_READ,
    output logic                     FIFO_EMPTY,
    output logic [31:0]              FIFO_DATA,
    output logic                     GRANT_VALID,
    output logic [3:0]               GRANT_ID
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       last_q, last_d;
    logic [3:0]       grant_q, grant_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [CHANNELS-1:0] req;
    logic                req_found;
    logic [3:0]          req_idx;

    logic                g_en;
    logic                g_empty;
    logic [31:0]         g_data;
    logic                grant_empty;
    logic                accept;
    logic [CNT_W-1:0]    burst_next;

    assign req = CH_ENABLE & ~CH_FIFO_EMPTY;

    // Search order starts just after the last served channel, wrapping modulo CHANNELS.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        req_found = 1'b0;
        req_idx   = 4'd0;
        for (int k = 1; k <= CHANNELS; k++) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!req_found && req[i] && (i == (int'(last_q) + k) % CHANNELS)) begin
                    req_found = 1'b1;
                    req_idx   = 4'(i);
                end
            end
        end
    end

    always_comb begin
        g_en    = 1'b0;
        g_empty = 1'b1;
        g_data  = 32'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i == int'(grant_q)) begin
                g_en    = CH_ENABLE[i];
                g_empty = CH_FIFO_EMPTY[i];
                g_data  = CH_FIFO_DATA[32*i +: 32];
            end
        end
    end

    assign grant_empty = g_empty | ~g_en;
    assign accept      = (state_q == ST_GRANT) & FIFO_READ & ~grant_empty;
    assign burst_next  = burst_cnt_q + CNT_W'(1);

    // The granted channel is passed straight through, so a read costs no extra cycle.
    always_comb begin
        FIFO_EMPTY   = 1'b1;
        FIFO_DATA    = 32'd0;
        CH_FIFO_READ = '0;
        GRANT_VALID  = 1'b0;
        GRANT_ID     = 4'd0;
        if (state_q == ST_GRANT) begin
            FIFO_EMPTY  = grant_empty;
`ifdef ARB_CHANNEL_TAG_EN
            FIFO_DATA   = {grant_q, g_data[27:0]};
`else
            FIFO_DATA   = g_data;
`endif
            GRANT_VALID = 1'b1;
            GRANT_ID    = grant_q;
            for (int i = 0; i < CHANNELS; i++) begin
                CH_FIFO_READ[i] = accept && (i == int'(grant_q));
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    grant_d     = req_idx;
                    burst_cnt_d = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    burst_cnt_d = burst_next;
                    if (burst_next == CNT_W'(MAX_BURST)) begin
                        state_d     = ST_IDLE;
                        last_d      = grant_q;
                        burst_cnt_d = '0;
                    end
                end else if (grant_empty) begin
                    // Drained or disabled: give the other lanes their turn.
                    state_d     = ST_IDLE;
                    last_d      = grant_q;
                    burst_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q     <= ST_IDLE;
            last_q      <= 4'(CHANNELS - 1);
            grant_q     <= 4'd0;
            burst_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_rx_aurora_readout_arbiter.sv
// Self-checking bench: FWFT channel FIFOs modelled as queues, burst-level round-robin reference model.
module tb_rx_aurora_readout_arbiter;

    localparam int CH = 4;
    localparam int MB = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [CH-1:0]       ch_en;
    logic [CH-1:0]       ch_empty;
    logic [32*CH-1:0]    ch_data;
    logic [CH-1:0]       ch_rd;
    logic                fifo_read;
    logic                fifo_empty;
    logic [31:0]         fifo_data;
    logic                gv;
    logic [3:0]          gid;

    typedef logic [31:0] word_q_t [$];
    word_q_t chq [CH];

    int checks = 0;
    int errors = 0;

    logic          s_empty, s_gv, s_accept;
    logic [31:0]   s_data;
    logic [3:0]    s_gid;
    logic [CH-1:0] s_rd;

    always #5 clk = ~clk;

    rx_aurora_readout_arbiter #(.CHANNELS(CH), .MAX_BURST(MB)) dut (
        .BUS_CLK      (clk),
        .BUS_RST_N    (rst_n),
        .CH_ENABLE    (ch_en),
        .CH_FIFO_EMPTY(ch_empty),
        .CH_FIFO_DATA (ch_data),
        .CH_FIFO_READ (ch_rd),
        .FIFO_READ    (fifo_read),
        .FIFO_EMPTY   (fifo_empty),
        .FIFO_DATA    (fifo_data),
        .GRANT_VALID  (gv),
        .GRANT_ID     (gid)
    );

    function automatic logic [31:0] tagged_word(input int c, input logic [31:0] w);
`ifdef ARB_CHANNEL_TAG_EN
        return {4'(c), w[27:0]};
`else
        return w;
`endif
    endfunction

    task automatic drive_fifos();
        for (int c = 0; c < CH; c++) begin
            if (chq[c].size() == 0) begin
                ch_empty[c]          = 1'b1;
                ch_data[32*c +: 32]  = 32'hDEAD_BE00 | 32'(c);
            end else begin
                ch_empty[c]          = 1'b0;
                ch_data[32*c +: 32]  = chq[c][0];
            end
        end
    endtask

    task automatic clear_fifos();
        for (int c = 0; c < CH; c++) chq[c].delete();
        drive_fifos();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: sample outputs at the falling edge, check them against the FIFO view, pop on the rising edge.
    task automatic cycle();
        int            g;
        logic          exp_empty;
        logic [CH-1:0] exp_rd;
        @(negedge clk);
        s_empty  = fifo_empty;
        s_data   = fifo_data;
        s_gv     = gv;
        s_gid    = gid;
        s_rd     = ch_rd;
        s_accept = s_gv && fifo_read && !s_empty;
        checks++;
        if (!s_gv) begin
            if (s_empty !== 1'b1 || s_data !== 32'd0 || s_rd !== '0) begin
                errors++;
                $display("FAIL idle_outputs: empty=%0b data=%h rd=%b, required empty=1 data=0 rd=0",
                         s_empty, s_data, s_rd);
            end
        end else if (int'(s_gid) >= CH) begin
            errors++;
            $display("FAIL grant_id_range: grant_id=%0d, required < %0d", s_gid, CH);
        end else begin
            g         = int'(s_gid);
            exp_empty = (chq[g].size() == 0) || !ch_en[g];
            exp_rd    = '0;
            if (fifo_read && !exp_empty) exp_rd[g] = 1'b1;
            if (s_empty !== exp_empty || s_rd !== exp_rd ||
                (!exp_empty && s_data !== tagged_word(g, chq[g][0]))) begin
                errors++;
                $display("FAIL grant_outputs: ch=%0d empty=%0b rd=%b data=%h, required empty=%0b rd=%b data=%h",
                         g, s_empty, s_rd, s_data, exp_empty, exp_rd,
                         exp_empty ? s_data : tagged_word(g, chq[g][0]));
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            if (s_rd[c] && chq[c].size() > 0) void'(chq[c].pop_front());
        end
        drive_fifos();
    endtask

    // Drain the current FIFO contents and compare against the round-robin burst sequence expected from reset.
    task automatic run_scenario(input bit rand_rd);
        int          taken [CH];
        int          exp_ch [$];
        logic [31:0] exp_w [$];
        int          exp_b [$];
        int          last, found, n, b, idx, cyc, budget, total, c;
        bit          saw_idle;
        for (int i = 0; i < CH; i++) taken[i] = 0;
        last = CH - 1;
        b    = 0;
        forever begin
            found = -1;
            for (int k = 1; k <= CH; k++) begin
                c = (last + k) % CH;
                if (found < 0 && ch_en[c] && (chq[c].size() - taken[c]) > 0) found = c;
            end
            if (found < 0) break;
            n = chq[found].size() - taken[found];
            if (n > MB) n = MB;
            for (int j = 0; j < n; j++) begin
                exp_ch.push_back(found);
                exp_w.push_back(tagged_word(found, chq[found][taken[found] + j]));
                exp_b.push_back(b);
            end
            taken[found] += n;
            last = found;
            b++;
        end
        total    = exp_w.size();
        budget   = 4 * total + 40;
        idx      = 0;
        cyc      = 0;
        saw_idle = 1'b1;
        while (idx < total && cyc < budget) begin
            fifo_read = rand_rd ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle();
            cyc++;
            if (s_accept) begin
                checks++;
                if (int'(s_gid) !== exp_ch[idx] || s_data !== exp_w[idx]) begin
                    errors++;
                    $display("FAIL word_order[%0d]: ch=%0d data=%h, required ch=%0d data=%h",
                             idx, s_gid, s_data, exp_ch[idx], exp_w[idx]);
                end
                if (idx > 0 && exp_b[idx] != exp_b[idx-1]) begin
                    checks++;
                    if (!saw_idle) begin
                        errors++;
                        $display("FAIL burst_gap[%0d]: no idle cycle between bursts, required >= 1", idx);
                    end
                end
                saw_idle = 1'b0;
                idx++;
            end else if (!s_gv) begin
                saw_idle = 1'b1;
            end
        end
        checks++;
        if (idx < total) begin
            errors++;
            $display("FAIL drain_timeout: %0d words read, required %0d", idx, total);
        end
        n = 0;
        fifo_read = 1'b1;
        repeat (8) begin
            cycle();
            if (s_accept) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL extra_words: %0d unexpected reads, required 0", n);
        end
    endtask

    task automatic test_reset();
        int bad;
        fifo_read = 1'b1;
        ch_en     = '1;
        clear_fifos();
        rst_n     = 1'b0;
        #3;
        checks += 5;
        if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: %0b, required 1", fifo_empty); end
        if (fifo_data !== 32'd0) begin errors++; $display("FAIL reset_data: %h, required 0", fifo_data); end
        if (gv !== 1'b0)         begin errors++; $display("FAIL reset_grant_valid: %0b, required 0", gv); end
        if (gid !== 4'd0)        begin errors++; $display("FAIL reset_grant_id: %0d, required 0", gid); end
        if (ch_rd !== '0)        begin errors++; $display("FAIL reset_ch_read: %b, required 0", ch_rd); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            cycle();
            if (s_gv || !s_empty || s_rd != '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL all_empty_idle: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_single_burst();
        bit  e_exp [9];
        bit  v_exp [9];
        int  w_exp [9];
        int  pulses;
        logic [CH-1:0] rd_exp;
        e_exp = '{1, 0, 0, 0, 0, 1, 0, 1, 1};
        v_exp = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
        w_exp = '{-1, 0, 1, 2, 3, -1, 4, -1, -1};
        clear_fifos();
        ch_en = '1;
        apply_reset();
        fifo_read = 1'b1;
        for (int i = 0; i < 5; i++) chq[1].push_back(32'hA0 + 32'(i));
        drive_fifos();
        pulses = 0;
        for (int t = 0; t < 9; t++) begin
            cycle();
            if (s_rd[1]) pulses++;
            rd_exp = (v_exp[t] && !e_exp[t]) ? 4'b0010 : 4'b0000;
            checks++;
            if (s_empty !== e_exp[t] || s_gv !== v_exp[t] || (v_exp[t] && s_gid !== 4'd1) ||
                s_rd !== rd_exp || (w_exp[t] >= 0 && s_data !== tagged_word(1, 32'hA0 + 32'(w_exp[t])))) begin
                errors++;
                $display("FAIL single_burst[%0d]: empty=%0b gv=%0b id=%0d rd=%b data=%h, required empty=%0b gv=%0b id=1 rd=%b word=%0d",
                         t, s_empty, s_gv, s_gid, s_rd, s_data, e_exp[t], v_exp[t], rd_exp, w_exp[t]);
            end
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL single_burst_pulses: %0d, required 5", pulses);
        end
    endtask

    task automatic test_round_robin();
        clear_fifos();
        ch_en = '1;
        for (int i = 0; i < 10; i++) begin
            chq[0].push_back(32'h0000_0100 + 32'(i));
            chq[2].push_back(32'h0000_0200 + 32'(i));
        end
        drive_fifos();
        apply_reset();
        run_scenario(1'b0);
    endtask

    task automatic test_disable_mid_burst();
        int n, cyc, bad;
        clear_fifos();
        ch_en = '1;
        apply_reset();
        fifo_read = 1'b1;
        for (int i = 0; i < 6; i++) chq[3].push_back(32'h3300_0000 + 32'(i));
        drive_fifos();
        n = 0;
        cyc = 0;
        while (n < 2 && cyc < 20) begin
            cycle();
            cyc++;
            if (s_accept) n++;
        end
        checks++;
        if (n < 2) begin errors++; $display("FAIL disable_setup: %0d reads, required 2", n); end
        ch_en[3] = 1'b0;
        #1;
        checks++;
        if (fifo_empty !== 1'b1 || gv !== 1'b1 || ch_rd !== '0) begin
            errors++;
            $display("FAIL disable_same_cycle: empty=%0b gv=%0b rd=%b, required empty=1 gv=1 rd=0",
                     fifo_empty, gv, ch_rd);
        end
        cycle();
        cycle();
        checks++;
        if (s_gv !== 1'b0) begin errors++; $display("FAIL disable_release: gv=%0b, required 0", s_gv); end
        bad = 0;
        repeat (20) begin
            cycle();
            if (s_gv) bad++;
        end
        checks += 2;
        if (bad != 0) begin errors++; $display("FAIL disabled_regrant: %0d grant cycles, required 0", bad); end
        if (chq[3].size() != 4) begin
            errors++;
            $display("FAIL disable_words_kept: %0d left, required 4", chq[3].size());
        end
        ch_en[3] = 1'b1;
        run_scenario(1'b0);
    endtask

    task automatic test_reset_mid_burst();
        int n, cyc;
        clear_fifos();
        ch_en = '1;
        for (int i = 0; i < 8; i++) chq[0].push_back(32'h0A00_0000 + 32'(i));
        for (int i = 0; i < 3; i++) chq[1].push_back(32'h1B00_0000 + 32'(i));
        drive_fifos();
        apply_reset();
        fifo_read = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 3 && cyc < 20) begin
            cycle();
            cyc++;
            if (s_accept) n++;
        end
        checks++;
        if (n < 3) begin errors++; $display("FAIL reset_mid_setup: %0d reads, required 3", n); end
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (fifo_empty !== 1'b1 || fifo_data !== 32'd0 || gv !== 1'b0 || gid !== 4'd0 || ch_rd !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: empty=%0b data=%h gv=%0b id=%0d rd=%b, required 1/0/0/0/0",
                     fifo_empty, fifo_data, gv, gid, ch_rd);
        end
        if (chq[0].size() != 5) begin
            errors++;
            $display("FAIL reset_mid_words_kept: %0d left, required 5", chq[0].size());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_scenario(1'b0);
    endtask

    task automatic test_channel_tag();
        logic [31:0] req_word;
        int          cyc;
        bit          got;
`ifdef ARB_CHANNEL_TAG_EN
        req_word = 32'h2FFF_1234;
`else
        req_word = 32'hFFFF_1234;
`endif
        clear_fifos();
        ch_en = '1;
        apply_reset();
        fifo_read = 1'b1;
        chq[2].push_back(32'hFFFF_1234);
        drive_fifos();
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 10) begin
            cycle();
            cyc++;
            if (s_accept) begin
                got = 1'b1;
                checks++;
                if (s_data !== req_word || s_gid !== 4'd2) begin
                    errors++;
                    $display("FAIL channel_tag: id=%0d data=%h, required id=2 data=%h", s_gid, s_data, req_word);
                end
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL channel_tag_timeout: no read, required 1"); end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 24; it++) begin
            clear_fifos();
            ch_en = CH'($urandom);
            for (int c = 0; c < CH; c++) begin
                n = $urandom_range(0, 9);
                for (int j = 0; j < n; j++) chq[c].push_back($urandom);
            end
            drive_fifos();
            apply_reset();
            run_scenario(1'b1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        fifo_read = 1'b0;
        ch_en     = '1;
        ch_empty  = '1;
        ch_data   = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_disable_mid_burst();
        test_reset_mid_burst();
        test_channel_tag();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
